// File: rtl/simd_mac_unit.sv
// 128-bit SIMD execute stage: int8/int16/int32 lane ops plus a 4x32 dot-product accumulator.
// Two register stages (S1 then OUT) under one global stall; OUT feeds the register-file write port.
module simd_mac_unit #(
  parameter int LANES32 = 4,
  parameter bit ACC_SAT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [32*LANES32-1:0]   src_a,
  input  logic [32*LANES32-1:0]   src_b,
  input  logic [4:0]              dest_reg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    wb_en,
  output logic [4:0]              wb_reg,
  output logic [32*LANES32-1:0]   wb_data,
  output logic                    illegal_op
);

  localparam int W  = 32 * LANES32;
  localparam int NB = 4 * LANES32;
  localparam int NH = 2 * LANES32;

  typedef enum logic [2:0] {
    OP_ADD8  = 3'b000,
    OP_ADD32 = 3'b001,
    OP_MUL16 = 3'b010,
    OP_DOT8  = 3'b011,
    OP_MAC8  = 3'b100,
    OP_ARD   = 3'b101,
    OP_ACLR  = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  logic advance;
  logic accept;

  logic                 s1_valid;
  logic [2:0]           s1_op;
  logic [4:0]           s1_dest;
  logic [W-1:0]         s1_res;
  logic [NB-1:0][15:0]  s1_prod;

  logic [W-1:0]         res_n;
  logic [NB-1:0][15:0]  prod_n;

  logic [2:0]           out_op;
  logic [4:0]           out_dest;
  logic [W-1:0]         out_data;

  logic [LANES32-1:0][31:0] acc;
  logic [LANES32-1:0][31:0] acc_n;
  logic [LANES32-1:0][31:0] dot;
  logic [LANES32-1:0][31:0] mac;
  logic [W-1:0]             out_n;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Stage-1 arithmetic: byte products for the dot ops, lane sums/products for the rest
  always_comb begin
    res_n  = '0;
    prod_n = '0;
    for (int i = 0; i < NB; i++) begin
      prod_n[i] = {{8{src_a[8*i+7]}}, src_a[8*i +: 8]}
                * {{8{src_b[8*i+7]}}, src_b[8*i +: 8]};
    end
    case (op)
      OP_ADD8: begin
        for (int i = 0; i < NB; i++)
          res_n[8*i +: 8] = src_a[8*i +: 8] + src_b[8*i +: 8];
      end
      OP_ADD32: begin
        for (int i = 0; i < LANES32; i++)
          res_n[32*i +: 32] = src_a[32*i +: 32] + src_b[32*i +: 32];
      end
      OP_MUL16: begin
        for (int i = 0; i < NH; i++)
          res_n[16*i +: 16] = src_a[16*i +: 16] * src_b[16*i +: 16];
      end
      default: res_n = '0;
    endcase
  end

  // OUT-stage reduction and accumulator read-modify-write
  always_comb begin
    logic [32:0] sum;
    dot   = '0;
    mac   = '0;
    acc_n = acc;
    out_n = s1_res;
    sum   = '0;
    for (int i = 0; i < LANES32; i++) begin
      for (int j = 0; j < 4; j++)
        dot[i] = dot[i] + {{16{s1_prod[4*i+j][15]}}, s1_prod[4*i+j]};
      sum = {acc[i][31], acc[i]} + {dot[i][31], dot[i]};
      if (ACC_SAT && (sum[32] != sum[31]))
        mac[i] = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else
        mac[i] = sum[31:0];
    end
    case (s1_op)
      OP_DOT8: out_n = dot;
      OP_MAC8: begin
        out_n = mac;
        acc_n = mac;
      end
      OP_ARD:  out_n = acc;
      OP_ACLR: begin
        out_n = '0;
        acc_n = '0;
      end
      OP_RSVD: out_n = '0;
      default: out_n = s1_res;
    endcase
  end

  // S1 register: captures accepted ops, holds under stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_dest  <= '0;
      s1_res   <= '0;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_dest <= dest_reg;
        s1_res  <= res_n;
        s1_prod <= prod_n;
      end
    end
  end

  // OUT register and accumulator: accumulator moves only with its op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_dest  <= '0;
      out_data  <= '0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_op   <= s1_op;
        out_dest <= s1_dest;
        out_data <= out_n;
        acc      <= acc_n;
      end
    end
  end

  // Sticky flag for accepted reserved ops
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_op <= 1'b0;
    else if (accept && (op == OP_RSVD))
      illegal_op <= 1'b1;
  end

  assign wb_reg  = out_dest;
  assign wb_data = out_data;
  assign wb_en   = out_valid && out_ready && (out_dest != 5'd0)
                && (out_op != OP_ACLR) && (out_op != OP_RSVD);

endmodule

// File: tb/tb_simd_mac_unit.sv
// Bench for simd_mac_unit: directed cases plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_simd_mac_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [127:0] src_a;
  logic [127:0] src_b;
  logic [4:0]   dest_reg;
  logic         out_valid;
  logic         out_ready;
  logic         wb_en;
  logic [4:0]   wb_reg;
  logic [127:0] wb_data;
  logic         illegal_op;

  simd_mac_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .dest_reg(dest_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   dest;
    bit           wr;
  } exp_t;

  exp_t         q[$];
  logic [127:0] hist_d[$];
  bit           hist_w[$];
  int           macc[4];
  bit           mill;
  bit           rand_ready;
  int           nvec = 0;
  int           nerr = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_res(input logic [2:0] o,
      input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    int           dt[4];
    int           p;
    longint       s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      dt[i] = 0;
      for (int j = 0; j < 4; j++)
        dt[i] += int'($signed(a[32*i+8*j +: 8])) * int'($signed(b[32*i+8*j +: 8]));
    end
    case (o)
      3'd0: for (int k = 0; k < 16; k++) r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
      3'd1: for (int k = 0; k < 4; k++) r[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
      3'd2: for (int k = 0; k < 8; k++) begin
        p = int'($signed(a[16*k +: 16])) * int'($signed(b[16*k +: 16]));
        r[16*k +: 16] = p[15:0];
      end
      3'd3: for (int k = 0; k < 4; k++) r[32*k +: 32] = dt[k];
      3'd4: for (int k = 0; k < 4; k++) begin
        s = longint'(macc[k]) + longint'(dt[k]);
        if (dut.ACC_SAT && s > 64'sd2147483647) s = 64'sd2147483647;
        if (dut.ACC_SAT && s < -64'sd2147483648) s = -64'sd2147483648;
        macc[k] = int'(s);
        r[32*k +: 32] = macc[k];
      end
      3'd5: for (int k = 0; k < 4; k++) r[32*k +: 32] = macc[k];
      3'd6: for (int k = 0; k < 4; k++) macc[k] = 0;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void push_model(input logic [2:0] o, input logic [127:0] a,
      input logic [127:0] b, input logic [4:0] d);
    exp_t e;
    e.data = model_res(o, a, b);
    e.dest = d;
    e.wr   = (d != 5'd0) && (o != 3'd6) && (o != 3'd7);
    if (o == 3'd7) mill = 1'b1;
    q.push_back(e);
  endfunction

  // Present one op and hold it until the unit takes it
  task automatic issue(input logic [2:0] o, input logic [127:0] a,
      input logic [127:0] b, input logic [4:0] d);
    bit ok;
    bit rdy;
    ok = 1'b0;
    op = o; src_a = a; src_b = b; dest_reg = d; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      #1;
    end
    if (ok) push_model(o, a, b, d);
    else begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles required acceptance");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    if (!rand_ready) out_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (q.size() == 0) break;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
      q.delete();
    end
  endtask

  // Every-cycle output check against the model queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL spurious_out: got out_valid=1 required no pending result");
          end else begin
            chk("wb_data", wb_data, q[0].data);
            chk("wb_reg", {123'd0, wb_reg}, {123'd0, q[0].dest});
            chk("wb_en", {127'd0, wb_en}, {127'd0, out_ready && q[0].wr});
            if (!out_ready) chk("in_ready_stall", {127'd0, in_ready}, 128'd0);
            if (out_ready) begin
              hist_d.push_back(wb_data);
              hist_w.push_back(wb_en);
              void'(q.pop_front());
            end
          end
        end else begin
          chk("wb_en_idle", {127'd0, wb_en}, 128'd0);
        end
        chk("illegal_op", {127'd0, illegal_op}, {127'd0, mill});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int           base;
    logic [127:0] v;
    logic [127:0] held;
    bit           seen;
    reset = 1'b1; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    dest_reg = '0; out_ready = 1'b1; rand_ready = 1'b0; mill = 1'b0;
    for (int i = 0; i < 4; i++) macc[i] = 0;
    #2;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_wb_en", {127'd0, wb_en}, 128'd0);
    chk("rst_wb_reg", {123'd0, wb_reg}, 128'd0);
    chk("rst_wb_data", wb_data, 128'd0);
    chk("rst_illegal", {127'd0, illegal_op}, 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD8 wrap and latency
    issue(3'd0, {16{8'hFF}}, {16{8'h01}}, 5'd5);
    chk("lat_not_yet", {127'd0, out_valid}, 128'd0);
    @(posedge clk); #1;
    chk("lat_valid", {127'd0, out_valid}, 128'd1);
    chk("add8_wb_en", {127'd0, wb_en}, 128'd1);
    chk("add8_wb_reg", {123'd0, wb_reg}, 128'd5);
    chk("add8_wb_data", wb_data, 128'd0);
    drain();

    // DOT8 signed
    base = hist_d.size();
    issue(3'd3, {64'd0, 32'h0000_00FF, 32'h0102_0304},
                {64'd0, 32'h0000_007F, 32'h0101_0101}, 5'd3);
    drain();
    v = hist_d[base];
    chk("dot8_lanes", v, {64'd0, 32'hFFFF_FF81, 32'h0000_000A});

    // MAC8 chain, read, clear
    base = hist_d.size();
    for (int i = 0; i < 3; i++)
      issue(3'd4, {96'd0, 32'h0102_0304}, {96'd0, 32'h0101_0101}, 5'd7);
    issue(3'd5, '0, '0, 5'd8);
    issue(3'd6, '0, '0, 5'd9);
    issue(3'd5, '0, '0, 5'd10);
    drain();
    v = hist_d[base];     chk("mac_1", v, 128'd10);
    v = hist_d[base + 1]; chk("mac_2", v, 128'd20);
    v = hist_d[base + 2]; chk("mac_3", v, 128'd30);
    v = hist_d[base + 3]; chk("acc_read_30", v, 128'd30);
    chk("acc_clr_wen", {127'd0, hist_w[base + 4]}, 128'd0);
    v = hist_d[base + 5]; chk("acc_read_0", v, 128'd0);

    // ADD32 stream with a 3-cycle downstream stall
    base = hist_d.size();
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(3'd1, {4{32'h1000_0000 + i}}, {4{32'h0000_0100}}, 5'(11 + i));
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(posedge clk); #1;
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("stall_seen", {127'd0, seen}, 128'd1);
        out_ready = 1'b0;
        held = wb_data;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
          chk("stall_hold", wb_data, held);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 128'(hist_d.size() - base), 128'd4);

    // dest 0 and reserved op
    base = hist_d.size();
    issue(3'd1, 128'd1, 128'd2, 5'd0);
    issue(3'd7, '1, '1, 5'd4);
    drain();
    chk("dest0_wen", {127'd0, hist_w[base]}, 128'd0);
    chk("rsvd_wen", {127'd0, hist_w[base + 1]}, 128'd0);
    chk("illegal_set", {127'd0, illegal_op}, 128'd1);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      issue(3'($urandom_range(0, 7)),
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            5'($urandom_range(0, 31)));
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    drain();
    chk("illegal_sticky", {127'd0, illegal_op}, 128'd1);

    // Reset with both stages full and acc=30
    issue(3'd6, '0, '0, 5'd1);
    for (int i = 0; i < 3; i++)
      issue(3'd4, {96'd0, 32'h0102_0304}, {96'd0, 32'h0101_0101}, 5'd7);
    drain();
    out_ready = 1'b0;
    issue(3'd5, '0, '0, 5'd2);
    issue(3'd1, 128'd5, 128'd6, 5'd3);
    chk("full_before_rst", {127'd0, out_valid}, 128'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_mid_wb_en", {127'd0, wb_en}, 128'd0);
    chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_mid_illegal", {127'd0, illegal_op}, 128'd0);
    q.delete();
    for (int i = 0; i < 4; i++) macc[i] = 0;
    mill = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    base = hist_d.size();
    issue(3'd5, '0, '0, 5'd2);
    drain();
    v = hist_d[base];
    chk("post_rst_acc", v, 128'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
